// File: rtl/ddr_rr_sched_pkg.sv
// Shared types and helpers for the DDR round-robin scheduler.
//   sched_state_e : transaction FSM states
//   ptr_width()   : width of a requester index, never below one bit
package ddr_rr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_e;

   function automatic int ptr_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr_rr_sched_rr_pick.sv
// Rotating-priority picker: the first set bit of i_valid, scanning from i_ptr
// upward modulo NREQ, wins.
//   i_valid  : request vector
//   i_ptr    : highest-priority slot this cycle (must be < NREQ)
//   o_grant  : one-hot grant, or 0 when nothing is valid
//   o_idx    : binary index of the granted slot
//   o_any    : at least one request is valid
module rr_pick
   import ddr_rr_sched_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int PTR_W = ptr_width(NREQ)
)(
   input  logic [NREQ-1:0]  i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant,
   output logic [PTR_W-1:0] o_idx,
   output logic             o_any
);

   logic [PTR_W:0]   w_sum;
   logic [PTR_W-1:0] w_sel;

   // Walk from the farthest slot back to i_ptr so the nearest valid slot is
   // the last writer and therefore the winner.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_sel   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
         if (w_sum >= (PTR_W + 1)'(NREQ)) begin
            w_sum = w_sum - (PTR_W + 1)'(NREQ);
         end
         w_sel = w_sum[PTR_W-1:0];
         if (i_valid[w_sel]) begin
            o_grant        = '0;
            o_grant[w_sel] = 1'b1;
            o_idx          = w_sel;
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_rr_sched.sv
// Round-robin scheduler sharing one DDR port between NREQ cache requesters
// (0 = dcache, 1 = icache, 2 = prefetcher). One transaction in flight.
//   clock, reset_n            : core clock, async active-low reset
//   req_*                     : per-slot request inputs, req_ready grant out
//   resp_done, resp_read_data : one-cycle completion pulse to the owner + data
//   ddr_*                     : DDR command/data pins and completion input
//   timeout_err               : sticky completion-watchdog flag
//
//   state | meaning
//   IDLE  | arbitrate; latch the winner's request on grant
//   ISSUE | strobe ddr_chip_enable on the first ddr_ready cycle
//   WAIT  | wait for ddr_operation_done; watchdog running
//   RESP  | pulse resp_done to the owner
module ddr_rr_sched
   import ddr_rr_sched_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int IDX_W   = 64,
   parameter int LINE_W  = 512,
   parameter int TIMEOUT = 1024
)(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*IDX_W-1:0]  req_index,
   input  logic [NREQ-1:0]        req_write_enable,
   input  logic [NREQ-1:0]        req_burst,
   input  logic [NREQ*LINE_W-1:0] req_write_data,
   output logic [NREQ-1:0]        resp_done,
   output logic [LINE_W-1:0]      resp_read_data,
   output logic                   ddr_chip_enable,
   output logic [IDX_W-1:0]       ddr_index,
   output logic                   ddr_write_enable,
   output logic                   ddr_burst_mode,
   output logic [LINE_W-1:0]      ddr_write_data,
   input  logic [LINE_W-1:0]      ddr_read_data,
   input  logic                   ddr_operation_done,
   input  logic                   ddr_ready,
   output logic                   timeout_err
);

   localparam int PTR_W = ptr_width(NREQ);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   sched_state_e      r_state;
   logic [PTR_W-1:0]  r_rr_ptr;
   logic [PTR_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_index;
   logic              r_we;
   logic              r_burst;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_rdata;
   logic [WD_W-1:0]   r_wd_cnt;
   logic              r_timeout_err;

   logic [NREQ-1:0]   w_grant;
   logic [PTR_W-1:0]  w_idx;
   logic              w_any;
   logic [PTR_W-1:0]  w_next_ptr;
   logic [IDX_W-1:0]  w_sel_index;
   logic              w_sel_we;
   logic              w_sel_burst;
   logic [LINE_W-1:0] w_sel_wdata;

   rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
      .i_valid (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_next_ptr = (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

   // Grant is one-hot, so a plain priority mux selects the winner's payload.
   always_comb begin
      w_sel_index = '0;
      w_sel_we    = 1'b0;
      w_sel_burst = 1'b0;
      w_sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel_index = req_index[i*IDX_W +: IDX_W];
            w_sel_we    = req_write_enable[i];
            w_sel_burst = req_burst[i];
            w_sel_wdata = req_write_data[i*LINE_W +: LINE_W];
         end
      end
   end

   // The watchdog flag rises at the edge that closes the TIMEOUT-th WAIT cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_rr_ptr      <= '0;
         r_owner       <= '0;
         r_index       <= '0;
         r_we          <= 1'b0;
         r_burst       <= 1'b0;
         r_wdata       <= '0;
         r_rdata       <= '0;
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner  <= w_idx;
                  r_rr_ptr <= w_next_ptr;
                  r_index  <= w_sel_index;
                  r_we     <= w_sel_we;
                  r_burst  <= w_sel_burst;
                  r_wdata  <= w_sel_wdata;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (ddr_ready) begin
                  r_wd_cnt <= '0;
                  r_state  <= WAIT;
               end
            end
            WAIT: begin
               if (r_wd_cnt < WD_W'(TIMEOUT)) begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
               if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  r_timeout_err <= 1'b1;
               end
               if (ddr_operation_done) begin
                  r_rdata <= ddr_read_data;
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign req_ready = (r_state == IDLE && reset_n) ? w_grant : '0;

   always_comb begin
      resp_done = '0;
      if (r_state == RESP) begin
         resp_done[r_owner] = 1'b1;
      end
   end

   assign ddr_chip_enable  = (r_state == ISSUE) && ddr_ready;
   assign ddr_index        = r_index;
   assign ddr_write_enable = r_we;
   assign ddr_burst_mode   = r_burst;
   assign ddr_write_data   = r_wdata;
   assign resp_read_data   = r_rdata;
   assign timeout_err      = r_timeout_err;

endmodule
